// File: rtl/safe_mode_sequencer_if.sv
// Control/status bundle of safe_mode_sequencer: "master" is the CPU wrapper side,
// "slave" is the sequencer. Signal names keep the legacy _i/_o port names.
interface safe_mode_sequencer_if #(
   parameter int unsigned NCores    = 3,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned IdxW      = (NCores > 1) ? $clog2(NCores) : 1
);
   logic                 start_i;
   logic                 cfg_src_sw_i;
   logic [IdxW-1:0]      ext_master_i;
   logic                 ext_safe_mode_i;
   logic [1:0]           ext_safe_cfg_i;
   logic                 ext_critical_i;
   logic [IdxW-1:0]      sw_master_i;
   logic                 sw_safe_mode_i;
   logic [1:0]           sw_safe_cfg_i;
   logic                 sw_critical_i;
   logic [AddrWidth-1:0] boot_addr_i;
   logic [NCores-1:0]    core_sync_ack_i;
   logic                 end_sw_routine_i;

   logic [IdxW-1:0]      master_core_o;
   logic                 safe_mode_o;
   logic [1:0]           safe_cfg_o;
   logic                 critical_section_o;
   logic [AddrWidth-1:0] entry_address_o;
   logic [NCores-1:0]    active_mask_o;
   logic [NCores-1:0]    fetch_en_o;
   logic                 sync_req_o;
   logic                 busy_o;
   logic                 done_o;
   logic                 error_o;
   logic [1:0]           err_code_o;

   modport master (
      output start_i, cfg_src_sw_i, ext_master_i, ext_safe_mode_i, ext_safe_cfg_i,
             ext_critical_i, sw_master_i, sw_safe_mode_i, sw_safe_cfg_i, sw_critical_i,
             boot_addr_i, core_sync_ack_i, end_sw_routine_i,
      input  master_core_o, safe_mode_o, safe_cfg_o, critical_section_o, entry_address_o,
             active_mask_o, fetch_en_o, sync_req_o, busy_o, done_o, error_o, err_code_o
   );

   modport slave (
      input  start_i, cfg_src_sw_i, ext_master_i, ext_safe_mode_i, ext_safe_cfg_i,
             ext_critical_i, sw_master_i, sw_safe_mode_i, sw_safe_cfg_i, sw_critical_i,
             boot_addr_i, core_sync_ack_i, end_sw_routine_i,
      output master_core_o, safe_mode_o, safe_cfg_o, critical_section_o, entry_address_o,
             active_mask_o, fetch_en_o, sync_req_o, busy_o, done_o, error_o, err_code_o
   );
endinterface

// File: rtl/safe_mode_sequencer.sv
// N-core safe-mode start/sync/end sequencer for the redundant CPU wrapper.
// Define SAFE_SEQ_TIMEOUT_EN to bound the sync barrier by TimeoutCycles.
module safe_mode_sequencer #(
   parameter int unsigned  NCores        = 3,
   parameter int unsigned  AddrWidth     = 32,
   parameter int unsigned  TimeoutCycles = 1024,
   localparam int unsigned IdxW          = (NCores > 1) ? $clog2(NCores) : 1
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   safe_mode_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_SYNC  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   localparam logic [1:0] CFG_DMR  = 2'b01;
   localparam logic [1:0] CFG_TMR  = 2'b10;
   localparam logic [1:0] CFG_RSVD = 2'b11;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CFG     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_ABORT   = 2'b11;

   if (NCores < 2 || TimeoutCycles < 2 || AddrWidth < 1) begin : g_param_check
      $error("safe_mode_sequencer: NCores and TimeoutCycles must be >= 2");
   end

   logic [2:0]        state, state_next;
   logic              start_q, start_rise;
   logic [NCores-1:0] ack_seen, ack_now, cfg_mask;
   logic              barrier_done, timeout_hit, cfg_bad, dmr_sel, tmr_sel;
   logic              err_set;
   logic [1:0]        err_code_set;
   int unsigned       master_idx, next_idx;

   assign start_rise   = bus.start_i & ~start_q;
   assign ack_now      = bus.core_sync_ack_i & bus.active_mask_o;
   assign barrier_done = ((ack_seen | ack_now) == bus.active_mask_o);

   // Mask derivation works on the latched outputs, which settle one cycle before CHECK.
   always_comb begin
      master_idx = 32'(bus.master_core_o);
      next_idx   = (master_idx + 1) % NCores;
      dmr_sel    = bus.safe_mode_o && (bus.safe_cfg_o == CFG_DMR);
      tmr_sel    = bus.safe_mode_o && (bus.safe_cfg_o == CFG_TMR);
      cfg_bad    = (bus.safe_cfg_o == CFG_RSVD) || (master_idx >= NCores) ||
                   (tmr_sel && ((NCores < 3) || (master_idx >= 3)));
      cfg_mask   = '0;
      for (int unsigned i = 0; i < NCores; i++) begin
         cfg_mask[i] = (i == master_idx) || (dmr_sel && (i == next_idx)) || (tmr_sel && (i < 3));
      end
   end

`ifdef SAFE_SEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] timeout_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)               timeout_cnt <= '0;
      else if (state != S_SYNC)  timeout_cnt <= '0;
      else                       timeout_cnt <= timeout_cnt + CntW'(1);
   end

   assign timeout_hit = (state == S_SYNC) && (timeout_cnt == CntW'(TimeoutCycles - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Abort outranks barrier completion in SYNC; end-of-routine outranks abort in RUN.
   always_comb begin
      state_next   = state;
      err_set      = 1'b0;
      err_code_set = ERR_NONE;
      case (state)
         S_IDLE:  if (start_rise) state_next = S_CHECK;
         S_CHECK: begin
            if (cfg_bad) begin
               state_next   = S_ERROR;
               err_set      = 1'b1;
               err_code_set = ERR_CFG;
            end else begin
               state_next = S_SYNC;
            end
         end
         S_SYNC: begin
            if (!bus.start_i) begin
               state_next   = S_ERROR;
               err_set      = 1'b1;
               err_code_set = ERR_ABORT;
            end else if (barrier_done) begin
               state_next = S_RUN;
            end else if (timeout_hit) begin
               state_next   = S_ERROR;
               err_set      = 1'b1;
               err_code_set = ERR_TIMEOUT;
            end
         end
         S_RUN: begin
            if (bus.end_sw_routine_i) begin
               state_next = S_DONE;
            end else if (!bus.start_i) begin
               state_next   = S_ERROR;
               err_set      = 1'b1;
               err_code_set = ERR_ABORT;
            end
         end
         S_DONE:  state_next = S_IDLE;
         S_ERROR: if (!bus.start_i) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state                  <= S_IDLE;
         start_q                <= 1'b0;
         ack_seen               <= '0;
         bus.master_core_o      <= '0;
         bus.safe_mode_o        <= 1'b0;
         bus.safe_cfg_o         <= '0;
         bus.critical_section_o <= 1'b0;
         bus.entry_address_o    <= '0;
         bus.active_mask_o      <= '0;
         bus.error_o            <= 1'b0;
         bus.err_code_o         <= '0;
      end else begin
         state   <= state_next;
         start_q <= bus.start_i;

         if (state == S_IDLE && start_rise) begin
            bus.master_core_o      <= bus.cfg_src_sw_i ? bus.sw_master_i    : bus.ext_master_i;
            bus.safe_mode_o        <= bus.cfg_src_sw_i ? bus.sw_safe_mode_i : bus.ext_safe_mode_i;
            bus.safe_cfg_o         <= bus.cfg_src_sw_i ? bus.sw_safe_cfg_i  : bus.ext_safe_cfg_i;
            bus.critical_section_o <= bus.cfg_src_sw_i ? bus.sw_critical_i  : bus.ext_critical_i;
            bus.entry_address_o    <= bus.boot_addr_i;
            bus.error_o            <= 1'b0;
            bus.err_code_o         <= ERR_NONE;
         end

         if (state == S_CHECK) bus.active_mask_o <= cfg_bad ? '0 : cfg_mask;

         if (state == S_SYNC && state_next == S_SYNC) ack_seen <= ack_seen | ack_now;
         else                                         ack_seen <= '0;

         if (err_set) begin
            bus.error_o    <= 1'b1;
            bus.err_code_o <= err_code_set;
         end
      end
   end

   assign bus.fetch_en_o = (state == S_SYNC || state == S_RUN) ? bus.active_mask_o : '0;
   assign bus.sync_req_o = (state == S_SYNC);
   assign bus.busy_o     = (state != S_IDLE);
   assign bus.done_o     = (state == S_DONE);
endmodule

// File: tb/tb_safe_mode_sequencer.sv
// Bench for safe_mode_sequencer: config table, hand-written corner sequences and a
// randomized run checked every cycle against a transaction-level model (NCores=3).
module tb_safe_mode_sequencer;
   localparam int unsigned N  = 3;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   safe_mode_sequencer_if #(.NCores(3), .AddrWidth(32)) bus3 ();
   safe_mode_sequencer_if #(.NCores(4), .AddrWidth(32)) bus4 ();

   safe_mode_sequencer #(.NCores(3), .AddrWidth(32), .TimeoutCycles(TO)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus3));
   safe_mode_sequencer #(.NCores(4), .AddrWidth(32), .TimeoutCycles(TO)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus4));

   typedef enum {P_IDLE, P_CHECK, P_SYNC, P_RUN, P_DONE, P_ERROR} phase_t;

   phase_t      ph;
   bit          m_prev_start;
   logic [1:0]  m_master, m_cfg, m_code;
   bit          m_sm, m_crit, m_err;
   logic [31:0] m_entry;
   logic [2:0]  m_mask, m_acked;
   int          m_sync_cycles;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Participating cores as a set: the master, plus its ring neighbour for DMR, or cores 0..2 for TMR.
   function automatic logic [2:0] plan_mask(input logic [1:0] master, input bit sm,
                                            input logic [1:0] cfg, output bit bad);
      int m;
      int mask;
      m    = int'(master);
      bad  = (cfg == 2'b11) || (m >= N) || (sm && cfg == 2'b10 && (N < 3 || m >= 3));
      mask = 0;
      if (!bad) begin
         mask = 1 << m;
         if (sm && cfg == 2'b01) mask = mask | (1 << ((m + 1) % N));
         if (sm && cfg == 2'b10) mask = 7;
      end
      return 3'(mask);
   endfunction

   task automatic model_reset();
      ph = P_IDLE; m_prev_start = 1'b0; m_master = '0; m_cfg = '0; m_code = '0;
      m_sm = 1'b0; m_crit = 1'b0; m_err = 1'b0; m_entry = '0; m_mask = '0;
      m_acked = '0; m_sync_cycles = 0;
   endtask

   task automatic model_step();
      bit st, rise, bad;
      logic [2:0] pm;
      st   = bus3.start_i;
      rise = st && !m_prev_start;
      case (ph)
         P_IDLE: if (rise) begin
            if (bus3.cfg_src_sw_i) begin
               m_master = bus3.sw_master_i; m_sm = bus3.sw_safe_mode_i;
               m_cfg = bus3.sw_safe_cfg_i; m_crit = bus3.sw_critical_i;
            end else begin
               m_master = bus3.ext_master_i; m_sm = bus3.ext_safe_mode_i;
               m_cfg = bus3.ext_safe_cfg_i; m_crit = bus3.ext_critical_i;
            end
            m_entry = bus3.boot_addr_i; m_err = 1'b0; m_code = 2'b00; ph = P_CHECK;
         end
         P_CHECK: begin
            pm = plan_mask(m_master, m_sm, m_cfg, bad);
            m_mask = pm;
            if (bad) begin m_err = 1'b1; m_code = 2'b01; ph = P_ERROR; end
            else begin ph = P_SYNC; m_acked = '0; m_sync_cycles = 0; end
         end
         P_SYNC: begin
            m_sync_cycles++;
            m_acked = m_acked | (bus3.core_sync_ack_i & m_mask);
            if (!st) begin m_err = 1'b1; m_code = 2'b11; ph = P_ERROR; end
            else if (m_acked == m_mask) ph = P_RUN;
`ifdef SAFE_SEQ_TIMEOUT_EN
            else if (m_sync_cycles == TO) begin m_err = 1'b1; m_code = 2'b10; ph = P_ERROR; end
`endif
         end
         P_RUN: begin
            if (bus3.end_sw_routine_i) ph = P_DONE;
            else if (!st) begin m_err = 1'b1; m_code = 2'b11; ph = P_ERROR; end
         end
         P_DONE:  ph = P_IDLE;
         P_ERROR: if (!st) ph = P_IDLE;
         default: ph = P_IDLE;
      endcase
      m_prev_start = st;
   endtask

   function automatic logic [49:0] dut_vec();
      return {bus3.master_core_o, bus3.safe_mode_o, bus3.safe_cfg_o, bus3.critical_section_o,
              bus3.entry_address_o, bus3.active_mask_o, bus3.fetch_en_o, bus3.sync_req_o,
              bus3.busy_o, bus3.done_o, bus3.error_o, bus3.err_code_o};
   endfunction

   function automatic logic [49:0] exp_vec();
      logic [2:0] fe;
      fe = (ph == P_SYNC || ph == P_RUN) ? m_mask : 3'b000;
      return {m_master, m_sm, m_cfg, m_crit, m_entry, m_mask, fe, ph == P_SYNC,
              ph != P_IDLE, ph == P_DONE, m_err, m_code};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      chk("scoreboard", 64'(dut_vec()), 64'(exp_vec()));
   endtask

   task automatic set_cfg(input bit sw, input logic [1:0] m, input bit sm,
                          input logic [1:0] cfg, input bit crit, input logic [31:0] addr);
      bus3.cfg_src_sw_i = sw;
      bus3.boot_addr_i  = addr;
      if (sw) begin
         bus3.sw_master_i = m;  bus3.sw_safe_mode_i = sm;  bus3.sw_safe_cfg_i = cfg;  bus3.sw_critical_i = crit;
         bus3.ext_master_i = ~m; bus3.ext_safe_mode_i = ~sm; bus3.ext_safe_cfg_i = ~cfg; bus3.ext_critical_i = ~crit;
      end else begin
         bus3.ext_master_i = m;  bus3.ext_safe_mode_i = sm;  bus3.ext_safe_cfg_i = cfg;  bus3.ext_critical_i = crit;
         bus3.sw_master_i = ~m; bus3.sw_safe_mode_i = ~sm; bus3.sw_safe_cfg_i = ~cfg; bus3.sw_critical_i = ~crit;
      end
   endtask

   task automatic go_idle();
      bus3.start_i = 1'b0; bus3.core_sync_ack_i = '0; bus3.end_sw_routine_i = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         if (!bus3.busy_o) break;
         cycle();
      end
      chk("go_idle_busy", 64'(bus3.busy_o), 64'(0));
   endtask

   typedef struct {
      bit         sw;
      logic [1:0] master;
      bit         sm;
      logic [1:0] cfg;
      logic [2:0] exp_mask;
      logic [1:0] exp_err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      tbl[0] = '{1'b0, 2'd2, 1'b1, 2'b01, 3'b101, 2'b00};
      tbl[1] = '{1'b1, 2'd0, 1'b1, 2'b10, 3'b111, 2'b00};
      tbl[2] = '{1'b0, 2'd1, 1'b1, 2'b00, 3'b010, 2'b00};
      tbl[3] = '{1'b0, 2'd1, 1'b0, 2'b10, 3'b010, 2'b00};
      tbl[4] = '{1'b1, 2'd2, 1'b1, 2'b11, 3'b000, 2'b01};
      tbl[5] = '{1'b0, 2'd3, 1'b1, 2'b00, 3'b000, 2'b01};
      tbl[6] = '{1'b1, 2'd1, 1'b1, 2'b10, 3'b111, 2'b00};
      tbl[7] = '{1'b0, 2'd0, 1'b1, 2'b01, 3'b011, 2'b00};
      tbl[8] = '{1'b1, 2'd1, 1'b0, 2'b11, 3'b000, 2'b01};

      rst_n = 1'b0;
      bus3.start_i = 1'b0; bus3.core_sync_ack_i = '0; bus3.end_sw_routine_i = 1'b0;
      set_cfg(1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 32'h0);
      bus4.start_i = 1'b0; bus4.cfg_src_sw_i = 1'b0; bus4.ext_master_i = '0;
      bus4.ext_safe_mode_i = 1'b0; bus4.ext_safe_cfg_i = '0; bus4.ext_critical_i = 1'b0;
      bus4.sw_master_i = '0; bus4.sw_safe_mode_i = 1'b0; bus4.sw_safe_cfg_i = '0;
      bus4.sw_critical_i = 1'b0; bus4.boot_addr_i = '0; bus4.core_sync_ack_i = '0;
      bus4.end_sw_routine_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 64'(dut_vec()), 64'(0));
      @(negedge clk) rst_n = 1'b1;

      // Configuration table
      for (int i = 0; i < 9; i++) begin
         go_idle();
         set_cfg(tbl[i].sw, tbl[i].master, tbl[i].sm, tbl[i].cfg, 1'b1, 32'(i) * 32'h100);
         bus3.start_i = 1'b1;
         cycle();
         chk($sformatf("tbl%0d_master", i), 64'(bus3.master_core_o), 64'(tbl[i].master));
         cycle();
         chk($sformatf("tbl%0d_mask", i), 64'(bus3.active_mask_o), 64'(tbl[i].exp_mask));
         chk($sformatf("tbl%0d_err", i), 64'(bus3.err_code_o), 64'(tbl[i].exp_err));
         chk($sformatf("tbl%0d_sync", i), 64'(bus3.sync_req_o), 64'(tbl[i].exp_err == 2'b00));
      end

      // DMR wrap-around, ack order 0 then 2, end pulse
      go_idle();
      set_cfg(1'b0, 2'd2, 1'b1, 2'b01, 1'b1, 32'h1C00_0080);
      bus3.start_i = 1'b1;
      cycle();
      chk("a_entry", 64'(bus3.entry_address_o), 64'h1C00_0080);
      cycle();
      chk("a_mask", 64'(bus3.active_mask_o), 64'(3'b101));
      chk("a_fetch_sync", 64'(bus3.fetch_en_o), 64'(3'b101));
      bus3.core_sync_ack_i = 3'b001; cycle(); bus3.core_sync_ack_i = '0;
      chk("a_wait_ack2", 64'(bus3.sync_req_o), 64'(1));
      bus3.core_sync_ack_i = 3'b100; cycle(); bus3.core_sync_ack_i = '0;
      chk("a_run_sync", 64'(bus3.sync_req_o), 64'(0));
      chk("a_run_fetch", 64'(bus3.fetch_en_o), 64'(3'b101));
      bus3.end_sw_routine_i = 1'b1; cycle(); bus3.end_sw_routine_i = 1'b0;
      chk("a_done", 64'(bus3.done_o), 64'(1));
      chk("a_done_fetch", 64'(bus3.fetch_en_o), 64'(0));
      cycle();
      chk("a_done_pulse", 64'(bus3.done_o), 64'(0));
      cycle();
      chk("a_no_restart", 64'(bus3.busy_o), 64'(0));

      // TMR with simultaneous acks
      go_idle();
      set_cfg(1'b1, 2'd0, 1'b1, 2'b10, 1'b0, 32'hABCD_0000);
      bus3.start_i = 1'b1;
      cycle(); cycle();
      chk("b_mask", 64'(bus3.active_mask_o), 64'(3'b111));
      bus3.core_sync_ack_i = 3'b111; cycle(); bus3.core_sync_ack_i = '0;
      chk("b_run", 64'({bus3.sync_req_o, bus3.fetch_en_o}), 64'(4'b0111));

      // Single mode: acks from non-active cores are ignored
      go_idle();
      set_cfg(1'b1, 2'd1, 1'b1, 2'b00, 1'b0, 32'h0000_1234);
      bus3.start_i = 1'b1;
      cycle(); cycle();
      bus3.core_sync_ack_i = 3'b101; cycle(); bus3.core_sync_ack_i = '0;
      chk("c_ignored_ack", 64'(bus3.sync_req_o), 64'(1));
      bus3.core_sync_ack_i = 3'b010; cycle(); bus3.core_sync_ack_i = '0;
      chk("c_run_fetch", 64'(bus3.fetch_en_o), 64'(3'b010));

      // Abort in RUN, sticky error, cleared by next accepted start
      bus3.start_i = 1'b0; cycle();
      chk("d_abort", 64'({bus3.error_o, bus3.err_code_o, bus3.fetch_en_o}), 64'({1'b1, 2'b11, 3'b000}));
      cycle();
      chk("d_sticky", 64'({bus3.busy_o, bus3.error_o}), 64'(2'b01));
      set_cfg(1'b0, 2'd1, 1'b1, 2'b01, 1'b0, 32'h5555_0000);
      bus3.start_i = 1'b1; cycle();
      chk("d_err_clear", 64'({bus3.error_o, bus3.err_code_o}), 64'(0));
      cycle();
      bus3.core_sync_ack_i = 3'b110; cycle(); bus3.core_sync_ack_i = '0;
      bus3.end_sw_routine_i = 1'b1; bus3.start_i = 1'b0; cycle(); bus3.end_sw_routine_i = 1'b0;
      chk("d_end_wins", 64'({bus3.done_o, bus3.error_o}), 64'(2'b10));

      // Reserved config: error held while start stays high
      go_idle();
      set_cfg(1'b0, 2'd1, 1'b1, 2'b11, 1'b0, 32'h0);
      bus3.start_i = 1'b1; cycle(); cycle();
      chk("e_cfg_err", 64'({bus3.error_o, bus3.err_code_o, bus3.fetch_en_o}), 64'({1'b1, 2'b01, 3'b000}));
      cycle();
      chk("e_held", 64'({bus3.busy_o, bus3.fetch_en_o}), 64'({1'b1, 3'b000}));

      // Sync barrier with one missing ack
      go_idle();
      set_cfg(1'b0, 2'd0, 1'b1, 2'b01, 1'b0, 32'h0);
      bus3.start_i = 1'b1; cycle(); cycle();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus3.sync_req_o) break;
         seen++;
         bus3.core_sync_ack_i = (i == 0) ? 3'b001 : 3'b000;
         cycle();
      end
      bus3.core_sync_ack_i = '0;
`ifdef SAFE_SEQ_TIMEOUT_EN
      chk("f_sync_cycles", 64'(seen), 64'(TO));
      chk("f_timeout", 64'({bus3.error_o, bus3.err_code_o}), 64'({1'b1, 2'b10}));
`else
      chk("f_sync_cycles", 64'(seen), 64'(20));
      chk("f_no_timeout", 64'({bus3.sync_req_o, bus3.error_o}), 64'(2'b10));
`endif

      // Async reset during SYNC, start held high across release
      go_idle();
      set_cfg(1'b0, 2'd0, 1'b1, 2'b01, 1'b1, 32'hFFFF_0000);
      bus3.start_i = 1'b1; cycle(); cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("g_async_reset", 64'({dut_vec(), bus4.busy_o}), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      cycle();
      chk("g_restart", 64'({bus3.busy_o, bus3.entry_address_o}), 64'({1'b1, 32'hFFFF_0000}));
      cycle();
      chk("g_restart_sync", 64'(bus3.sync_req_o), 64'(1));
      go_idle();

      // NCores=4 instance: TMR with master 3 invalid, DMR from core 3 wraps to core 0
      bus4.ext_master_i = 2'd3; bus4.ext_safe_mode_i = 1'b1; bus4.ext_safe_cfg_i = 2'b10;
      bus4.start_i = 1'b1; cycle(); cycle();
      chk("h_tmr_bad", 64'({bus4.error_o, bus4.err_code_o, bus4.fetch_en_o}), 64'({1'b1, 2'b01, 4'b0000}));
      bus4.start_i = 1'b0; cycle();
      bus4.ext_safe_cfg_i = 2'b01;
      bus4.start_i = 1'b1; cycle(); cycle();
      chk("h_dmr_wrap", 64'(bus4.active_mask_o), 64'(4'b1001));
      bus4.start_i = 1'b0; cycle(); cycle();

      // Randomized run against the model
      go_idle();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) bus3.start_i = ~bus3.start_i;
         bus3.cfg_src_sw_i     = 1'($urandom_range(0, 1));
         bus3.ext_master_i     = 2'($urandom_range(0, 3));
         bus3.ext_safe_mode_i  = 1'($urandom_range(0, 1));
         bus3.ext_safe_cfg_i   = 2'($urandom_range(0, 3));
         bus3.ext_critical_i   = 1'($urandom_range(0, 1));
         bus3.sw_master_i      = 2'($urandom_range(0, 3));
         bus3.sw_safe_mode_i   = 1'($urandom_range(0, 1));
         bus3.sw_safe_cfg_i    = 2'($urandom_range(0, 3));
         bus3.sw_critical_i    = 1'($urandom_range(0, 1));
         bus3.boot_addr_i      = $urandom;
         bus3.core_sync_ack_i  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         bus3.end_sw_routine_i = ($urandom_range(0, 9) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
